// File: rtl/sw_debounce_pkg.sv
// Shared definitions for the switch debouncer: per-bit state encoding and default timing.
package sw_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'b00,
    ST_LOW_CHK  = 2'b01,
    ST_HIGH     = 2'b10,
    ST_HIGH_CHK = 2'b11
  } db_state_e;

  // Defaults give a 1 ms tick at 100 MHz and a 10 ms acceptance window.
  localparam int DEF_NB_SW        = 4;
  localparam int DEF_NB_PRESCALE  = 17;
  localparam int DEF_PRESCALE_MAX = 99999;
  localparam int DEF_NB_STABLE    = 4;
  localparam int DEF_STABLE_TICKS = 10;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce FSM and tick-based stability counter.
//
// state       | meaning
// ST_LOW      | accepted level 0, input agrees
// ST_LOW_CHK  | accepted level 0, input at 1, counting stable ticks
// ST_HIGH     | accepted level 1, input agrees
// ST_HIGH_CHK | accepted level 1, input at 0, counting stable ticks
module sw_debounce_bit
  import sw_debounce_pkg::*;
#(
  parameter int NB_STABLE    = DEF_NB_STABLE,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clock,
  input  logic i_reset,
  input  logic i_sw,
  input  logic i_tick,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_edge_next
);

  localparam logic [NB_STABLE-1:0] CNT_LAST = NB_STABLE'(STABLE_TICKS - 1);

  logic [1:0]           sync_q;
  logic                 s;
  db_state_e            state_q, state_d;
  logic [NB_STABLE-1:0] cnt_q, cnt_d;
  logic                 level_d, rise_d, fall_d;

  assign s = sync_q[1];

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q  <= '0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      o_level <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_sw};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_level <= level_d;
      o_rise  <= rise_d;
      o_fall  <= fall_d;
    end
  end

  // A revert of s always beats a coincident tick, so a bounce is never counted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = o_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_LOW_CHK;
          cnt_d   = '0;
        end
      end
      ST_LOW_CHK: begin
        if (!s) begin
          state_d = ST_LOW;
        end else if (i_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_HIGH;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_HIGH_CHK;
          cnt_d   = '0;
        end
      end
      ST_HIGH_CHK: begin
        if (s) begin
          state_d = ST_HIGH;
        end else if (i_tick) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_LOW;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_LOW;
    endcase
  end

  assign o_edge_next = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// Switch debouncer top: shared tick prescaler, per-bit debouncers and aggregate change pulse.
module sw_debounce
  import sw_debounce_pkg::*;
#(
  parameter int NB_SW        = DEF_NB_SW,
  parameter int NB_PRESCALE  = DEF_NB_PRESCALE,
  parameter int PRESCALE_MAX = DEF_PRESCALE_MAX,
  parameter int NB_STABLE    = DEF_NB_STABLE,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic [NB_SW-1:0] i_sw,
  output logic [NB_SW-1:0] o_sw,
  output logic [NB_SW-1:0] o_rise,
  output logic [NB_SW-1:0] o_fall,
  output logic             o_change
);

  localparam logic [NB_PRESCALE-1:0] PRESC_LAST = NB_PRESCALE'(PRESCALE_MAX);

  logic [NB_PRESCALE-1:0] presc_q;
  logic                   tick;
  logic [NB_SW-1:0]       edge_next;

  assign tick = (presc_q == PRESC_LAST);

  // Free-running: switch activity never disturbs the tick phase.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NB_SW; g++) begin : g_bit
    sw_debounce_bit #(
      .NB_STABLE    (NB_STABLE),
      .STABLE_TICKS (STABLE_TICKS)
    ) u_bit (
      .clock       (clock),
      .i_reset     (i_reset),
      .i_sw        (i_sw[g]),
      .i_tick      (tick),
      .o_level     (o_sw[g]),
      .o_rise      (o_rise[g]),
      .o_fall      (o_fall[g]),
      .o_edge_next (edge_next[g])
    );
  end

  // Registered from next-state pulses so it lines up with o_rise/o_fall.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_change <= 1'b0;
    end else begin
      o_change <= |edge_next;
    end
  end

endmodule
